// File: rtl/jt1942_sndlatch_pkg.sv
// Shared constants for the jt1942 sound latch block.
// Holds the default timing parameters, the reset FSM encoding and a counter-width helper.
package jt1942_sndlatch_pkg;

   localparam int unsigned IntTimeoutDef = 256;
   localparam int unsigned RstHoldDef    = 16;

   // Sound CPU reset sequencer states
   localparam logic [1:0] StRun  = 2'd0;
   localparam logic [1:0] StRst  = 2'd1;
   localparam logic [1:0] StHold = 2'd2;

   // Down-counter width for a count of n, never narrower than one bit
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jt1942_sndirq.sv
// Sound CPU interrupt generator: snd_int rising-edge detect, acknowledge and timeout release.
// While en_i is low the IRQ is forced inactive and edges are ignored.
module jt1942_sndirq
   import jt1942_sndlatch_pkg::*;
#(
   parameter int unsigned INT_TIMEOUT = IntTimeoutDef
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic cen_i,
   input  logic en_i,
   input  logic snd_int_i,
   input  logic ack_i,
   output logic snd_int_no
);

   localparam int unsigned TW = cnt_w(INT_TIMEOUT);
   localparam logic [TW-1:0] TimerLoad = TW'(INT_TIMEOUT - 1);

   logic          int_n_q, int_n_d;
   logic          last_q, last_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          edge_det;

   assign edge_det = snd_int_i & ~last_q;

   always_comb begin
      int_n_d = int_n_q;
      last_d  = last_q;
      timer_d = timer_q;
      if (cen_i) begin
         last_d = snd_int_i;
         if (!en_i) begin
            int_n_d = 1'b1;
            timer_d = '0;
         end else if (edge_det) begin
            // A fresh edge beats a same-cycle acknowledge and restarts the timeout
            int_n_d = 1'b0;
            timer_d = TimerLoad;
         end else if (!int_n_q) begin
            if (ack_i || timer_q == '0) begin
               int_n_d = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         int_n_q <= 1'b1;
         last_q  <= 1'b1;
         timer_q <= '0;
      end else begin
         int_n_q <= int_n_d;
         last_q  <= last_d;
         timer_q <= timer_d;
      end
   end

   assign snd_int_no = int_n_q;

endmodule

// File: rtl/jt1942_sndlatch.sv
// Main-to-sound CPU command latches with unread/overwrite flags, sound IRQ and reset sequencer.
// The main CPU writes two byte latches; the sound CPU reads them back through snd_din.
module jt1942_sndlatch
   import jt1942_sndlatch_pkg::*;
#(
   parameter int unsigned INT_TIMEOUT = IntTimeoutDef,
   parameter int unsigned RST_HOLD    = RstHoldDef
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen3,
   input  logic [7:0] main_dout,
   input  logic       snd_latch0_cs,
   input  logic       snd_latch1_cs,
   input  logic       snd_int,
   input  logic       sres_b,
   input  logic       snd_cs,
   input  logic       snd_A,
   input  logic       snd_rd_n,
   input  logic       snd_iorq_n,
   input  logic       snd_m1_n,
   output logic [7:0] snd_din,
   output logic       snd_int_n,
   output logic       snd_rst_n,
   output logic [1:0] latch_pend,
   output logic [1:0] latch_ovf
);

   localparam int unsigned HW = cnt_w(RST_HOLD);
   localparam logic [HW-1:0] HoldLoad = HW'(RST_HOLD - 1);

   logic [1:0][7:0] latch_q, latch_d;
   logic [1:0]      pend_q, pend_d;
   logic [1:0]      ovf_q, ovf_d;
   logic            rd_q, rd_d;
   logic            rd_idx_q, rd_idx_d;
   logic [1:0]      state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;

   logic       run;
   logic       rd_act;
   logic       rd_end;
   logic [1:0] rd_clr;
   logic [1:0] wr;
   logic       irq_ack;

   assign run     = (state_q == StRun);
   assign rd_act  = snd_cs & ~snd_rd_n;
   assign wr      = {snd_latch1_cs, snd_latch0_cs} & {2{cen3}};
   assign irq_ack = ~snd_iorq_n & ~snd_m1_n;

   assign snd_din = rd_act ? latch_q[snd_A] : 8'hff;

   // Read tracking: the latch index is captured at read start, pend clears at read end
   always_comb begin
      rd_d     = rd_q;
      rd_idx_d = rd_idx_q;
      rd_end   = 1'b0;
      if (cen3) begin
         if (!run) begin
            rd_d = 1'b0;
         end else begin
            rd_d   = rd_act;
            rd_end = rd_q & ~rd_act;
            if (rd_act && !rd_q) begin
               rd_idx_d = snd_A;
            end
         end
      end
   end

   assign rd_clr = rd_end ? (rd_idx_q ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      latch_d = latch_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      for (int i = 0; i < 2; i++) begin
         if (wr[i]) begin
            latch_d[i] = main_dout;
         end
         if (cen3) begin
            if (!run) begin
               pend_d[i] = 1'b0;
            end else if (wr[i]) begin
               // A write landing on the read-end cycle replaces consumed data, not unread data
               if (pend_q[i] && !rd_clr[i]) begin
                  ovf_d[i] = 1'b1;
               end
               pend_d[i] = 1'b1;
            end else if (rd_clr[i]) begin
               pend_d[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (cen3) begin
         case (state_q)
            StRun: begin
               if (!sres_b) begin
                  state_d = StRst;
               end
            end
            StRst: begin
               if (sres_b) begin
                  state_d = StHold;
                  hold_d  = HoldLoad;
               end
            end
            StHold: begin
               if (!sres_b) begin
                  state_d = StRst;
               end else if (hold_q == '0) begin
                  state_d = StRun;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
            default: begin
               state_d = StRst;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latch_q  <= '0;
         pend_q   <= '0;
         ovf_q    <= '0;
         rd_q     <= 1'b0;
         rd_idx_q <= 1'b0;
         state_q  <= StHold;
         hold_q   <= HoldLoad;
      end else begin
         latch_q  <= latch_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         rd_q     <= rd_d;
         rd_idx_q <= rd_idx_d;
         state_q  <= state_d;
         hold_q   <= hold_d;
      end
   end

   jt1942_sndirq #(
      .INT_TIMEOUT (INT_TIMEOUT)
   ) u_irq (
      .clk_i      (clk),
      .rst_i      (rst),
      .cen_i      (cen3),
      .en_i       (run),
      .snd_int_i  (snd_int),
      .ack_i      (irq_ack),
      .snd_int_no (snd_int_n)
   );

   assign snd_rst_n  = run;
   assign latch_pend = pend_q;
   assign latch_ovf  = ovf_q;

endmodule

// File: tb/tb_jt1942_sndlatch.sv
// Directed bench for jt1942_sndlatch: latch read/write flags, IRQ timing and reset sequencing.
module tb_jt1942_sndlatch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen3 = 1'b0;
   logic [7:0] main_dout = 8'h00;
   logic       snd_latch0_cs = 1'b0;
   logic       snd_latch1_cs = 1'b0;
   logic       snd_int = 1'b0;
   logic       sres_b = 1'b1;
   logic       snd_cs = 1'b0;
   logic       snd_A = 1'b0;
   logic       snd_rd_n = 1'b1;
   logic       snd_iorq_n = 1'b1;
   logic       snd_m1_n = 1'b1;
   logic [7:0] snd_din;
   logic       snd_int_n;
   logic       snd_rst_n;
   logic [1:0] latch_pend;
   logic [1:0] latch_ovf;

   int total = 0;
   int bad = 0;
   int n;

   jt1942_sndlatch #(
      .INT_TIMEOUT (256),
      .RST_HOLD    (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cen3          (cen3),
      .main_dout     (main_dout),
      .snd_latch0_cs (snd_latch0_cs),
      .snd_latch1_cs (snd_latch1_cs),
      .snd_int       (snd_int),
      .sres_b        (sres_b),
      .snd_cs        (snd_cs),
      .snd_A         (snd_A),
      .snd_rd_n      (snd_rd_n),
      .snd_iorq_n    (snd_iorq_n),
      .snd_m1_n      (snd_m1_n),
      .snd_din       (snd_din),
      .snd_int_n     (snd_int_n),
      .snd_rst_n     (snd_rst_n),
      .latch_pend    (latch_pend),
      .latch_ovf     (latch_ovf)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cen3 = ~cen3;

   task automatic tick();
      do @(posedge clk); while (!cen3);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_latch(input logic idx, input logic [7:0] d);
      main_dout = d;
      snd_latch0_cs = ~idx;
      snd_latch1_cs = idx;
      tick();
      snd_latch0_cs = 1'b0;
      snd_latch1_cs = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_int_n", snd_int_n, 1);
      chk("rst_snd_rst_n", snd_rst_n, 0);
      chk("rst_pend", latch_pend, 0);
      chk("rst_ovf", latch_ovf, 0);
      chk("rst_din", snd_din, 8'hff);

      // Release: sound CPU reset held for RST_HOLD cen3 cycles
      rst = 1'b0;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         n++;
         if (snd_rst_n) break;
      end
      chk("por_hold_len", n, 16);
      chk("din_unselected", snd_din, 8'hff);

      // Single write then read of latch0
      wr_latch(1'b0, 8'h5a);
      chk("wr0_pend", latch_pend, 2'b01);
      snd_cs = 1'b1; snd_A = 1'b0; snd_rd_n = 1'b0;
      #1;
      chk("rd0_data", snd_din, 8'h5a);
      tick();
      tick();
      chk("rd0_pend_during", latch_pend, 2'b01);
      snd_cs = 1'b0; snd_rd_n = 1'b1;
      tick();
      chk("rd0_pend_after", latch_pend, 2'b00);
      chk("rd0_ovf", latch_ovf, 2'b00);

      // Double write to latch1 sets sticky overflow
      wr_latch(1'b1, 8'h11);
      wr_latch(1'b1, 8'h22);
      chk("wr1_pend", latch_pend, 2'b10);
      chk("wr1_ovf", latch_ovf, 2'b10);
      snd_cs = 1'b1; snd_A = 1'b1; snd_rd_n = 1'b0;
      #1;
      chk("rd1_data", snd_din, 8'h22);
      tick();
      snd_cs = 1'b0; snd_rd_n = 1'b1;
      tick();
      chk("rd1_pend_after", latch_pend, 2'b00);
      chk("rd1_ovf_sticky", latch_ovf, 2'b10);

      // Write coinciding with read end on latch0
      wr_latch(1'b0, 8'h33);
      snd_cs = 1'b1; snd_A = 1'b0; snd_rd_n = 1'b0;
      tick();
      snd_cs = 1'b0; snd_rd_n = 1'b1;
      main_dout = 8'h44; snd_latch0_cs = 1'b1;
      tick();
      snd_latch0_cs = 1'b0;
      chk("coll_pend", latch_pend, 2'b01);
      chk("coll_ovf", latch_ovf, 2'b10);
      snd_cs = 1'b1; snd_rd_n = 1'b0;
      #1;
      chk("coll_data", snd_din, 8'h44);
      tick();
      snd_cs = 1'b0; snd_rd_n = 1'b1;
      tick();
      chk("coll_pend_after", latch_pend, 2'b00);

      // IRQ acknowledged on the 10th cen3 after the edge
      snd_int = 1'b1;
      tick();
      chk("irq_assert", snd_int_n, 0);
      n = 1;
      for (int k = 1; k <= 10; k++) begin
         if (k == 10) begin
            snd_iorq_n = 1'b0; snd_m1_n = 1'b0;
         end
         tick();
         if (!snd_int_n) n++;
      end
      snd_iorq_n = 1'b1; snd_m1_n = 1'b1;
      chk("irq_ack_len", n, 10);
      tick();
      chk("irq_ack_release", snd_int_n, 1);

      // IRQ without acknowledge times out
      snd_int = 1'b0;
      tick();
      snd_int = 1'b1;
      tick();
      n = 1;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (snd_int_n) break;
         n++;
      end
      chk("irq_timeout_len", n, 256);

      // Edge and acknowledge in the same cycle: the edge wins
      snd_int = 1'b0;
      tick();
      snd_int = 1'b1; snd_iorq_n = 1'b0; snd_m1_n = 1'b0;
      tick();
      chk("irq_edge_wins", snd_int_n, 0);
      tick();
      chk("irq_ack_after_edge", snd_int_n, 1);
      snd_iorq_n = 1'b1; snd_m1_n = 1'b1;

      // Sound reset from the main CPU
      snd_int = 1'b0;
      wr_latch(1'b0, 8'h66);
      chk("sres_pre_pend", latch_pend, 2'b01);
      sres_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) snd_int = 1'b1;
         tick();
      end
      chk("sres_rst_n_low", snd_rst_n, 0);
      chk("sres_pend_clr", latch_pend, 2'b00);
      chk("sres_irq_ignored", snd_int_n, 1);
      sres_b = 1'b1;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         n++;
         if (snd_rst_n) break;
      end
      chk("sres_release_len", n, 17);
      chk("sres_pend_after", latch_pend, 2'b00);
      chk("sres_ovf_kept", latch_ovf, 2'b10);
      snd_cs = 1'b1; snd_A = 1'b0; snd_rd_n = 1'b0;
      #1;
      chk("sres_latch_kept", snd_din, 8'h66);
      tick();
      snd_cs = 1'b0; snd_rd_n = 1'b1;
      tick();

      // Asynchronous reset mid-IRQ and mid-read
      snd_int = 1'b0;
      tick();
      snd_int = 1'b1;
      tick();
      chk("mid_irq_active", snd_int_n, 0);
      wr_latch(1'b0, 8'h88);
      snd_cs = 1'b1; snd_A = 1'b0; snd_rd_n = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("arst_int_n", snd_int_n, 1);
      chk("arst_pend", latch_pend, 2'b00);
      chk("arst_rst_n", snd_rst_n, 0);
      tick();
      snd_cs = 1'b0; snd_rd_n = 1'b1;
      rst = 1'b0;
      tick();
      tick();
      chk("arst_pend_after", latch_pend, 2'b00);
      chk("arst_ovf_after", latch_ovf, 2'b00);
      chk("arst_int_n_after", snd_int_n, 1);
      snd_cs = 1'b1; snd_rd_n = 1'b0;
      #1;
      chk("arst_latch_clr", snd_din, 8'h00);
      snd_cs = 1'b0; snd_rd_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
